// File: rtl/shift_sequencer_if.sv
// Bundle of request, response and shift-unit signals for shift_sequencer.
// slave: the sequencer side. master: the requester that also models the
// external single-bit shift/rotate unit.
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    // Request side
    logic             start;
    logic [2:0]       op_in;
    logic [WIDTH-1:0] data_in;
    logic [AMT_W-1:0] amount;

    // Shift/rotate unit side
    logic [WIDTH-1:0] sr_a;
    logic [2:0]       sr_opcode;
    logic [WIDTH-1:0] sr_result;

    // Status / response
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result_out;

    modport slave (
        input  start, op_in, data_in, amount, sr_result,
        output sr_a, sr_opcode, busy, done, err, result_out
    );

    modport master (
        output start, op_in, data_in, amount, sr_result,
        input  sr_a, sr_opcode, busy, done, err, result_out
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-step controller that iterates a combinational 1-bit shift/rotate
// unit 0..2**AMT_W-1 times, turning it into a small barrel shifter.
// The accumulator feeds the unit; the unit's result is written back once per
// clock until the step count runs out, then the value is presented with done.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    shift_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Highest opcode the shift unit understands (rol)
    localparam logic [2:0] OP_MAX = 3'b101;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             accept;

    // A request is taken whenever the sequencer is not mid-operation, so a
    // new start in the DONE cycle chains operations back to back.
    assign accept = bus.start && (state_q != SHIFT);

    // State and datapath registers; async reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            result_q <= '0;
            op_q     <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            op_q     <= op_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath update: accept in IDLE/DONE, iterate in SHIFT.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        op_d     = op_q;
        count_d  = count_q;
        err_d    = err_q;

        case (state_q)
            SHIFT: begin
                acc_d   = bus.sr_result;
                count_d = count_q - AMT_W'(1);
                // Last step: the unit's output is the final answer.
                if (count_q == AMT_W'(1)) begin
                    result_d = bus.sr_result;
                    state_d  = DONE;
                end
            end
            default: begin
                // IDLE, DONE (and the unused encoding) fall back to IDLE
                // unless a new request arrives.
                state_d = IDLE;
                if (accept) begin
                    acc_d   = bus.data_in;
                    op_d    = bus.op_in;
                    count_d = bus.amount;
                    err_d   = 1'b0;
                    if (bus.op_in > OP_MAX) begin
                        // Unknown opcode: report immediately, no shifting.
                        state_d  = DONE;
                        result_d = '0;
                        err_d    = 1'b1;
                    end else if (bus.amount == '0) begin
                        // Zero steps: pass the operand straight through,
                        // which also keeps count from ever wrapping.
                        state_d  = DONE;
                        result_d = bus.data_in;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
        endcase
    end

    // Outputs are register copies or state decodes only.
    assign bus.sr_a       = acc_q;
    assign bus.sr_opcode  = op_q;
    assign bus.busy       = (state_q == SHIFT);
    assign bus.done       = (state_q == DONE);
    assign bus.err        = err_q;
    assign bus.result_out = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the external 1-bit shift/rotate unit and
// checks results against a whole-operation barrel-shift reference.
module tb_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External single-bit shift/rotate unit
    always_comb begin
        case (bus.sr_opcode)
            3'b000:  bus.sr_result = {bus.sr_a[7], bus.sr_a[7:1]};
            3'b001:  bus.sr_result = {1'b0, bus.sr_a[7:1]};
            3'b010:  bus.sr_result = {bus.sr_a[6:0], 1'b0};
            3'b011:  bus.sr_result = {bus.sr_a[6:0], 1'b0};
            3'b100:  bus.sr_result = {bus.sr_a[0], bus.sr_a[7:1]};
            3'b101:  bus.sr_result = {bus.sr_a[6:0], bus.sr_a[7]};
            default: bus.sr_result = bus.sr_a;
        endcase
    end

    // Reference: whole n-bit shift in one step
    function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] d, input int n);
        logic [15:0]      dd;
        logic [15:0]      sh;
        logic signed [7:0] s;
        logic [7:0]       r;
        dd = {d, d};
        s  = d;
        r  = 8'h00;
        case (op)
            3'd0: r = s >>> n;
            3'd1: r = d >> n;
            3'd2, 3'd3: r = 8'(d << n);
            3'd4: begin sh = dd >> n; r = sh[7:0]; end
            3'd5: begin sh = dd << n; r = sh[15:8]; end
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Issue one request at the current negedge and wait (bounded) for done.
    // Returns with time at the negedge of the done cycle, or lat=-1 on timeout.
    task automatic run_op(input logic [2:0] op, input logic [7:0] d, input logic [2:0] n,
                          output int lat, output logic [7:0] res, output logic e, output bit saw_busy);
        bus.start   = 1'b1;
        bus.op_in   = op;
        bus.data_in = d;
        bus.amount  = n;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.op_in   = 3'($urandom);
        bus.data_in = 8'($urandom);
        bus.amount  = 3'($urandom);
        lat = -1;
        saw_busy = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            if (bus.busy) saw_busy = 1'b1;
            if (bus.done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        res = bus.result_out;
        e   = bus.err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b expected 000", {bus.busy, bus.done, bus.err});
        end
        checks++;
        if ({bus.result_out, bus.sr_a, bus.sr_opcode} !== 19'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h expected 0/0/0", bus.result_out, bus.sr_a, bus.sr_opcode);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release got %b expected 00", {bus.busy, bus.done});
        end
        $display("test_reset done");
    endtask

    task automatic test_sra();
        bus.start = 1'b1; bus.op_in = 3'd0; bus.data_in = 8'h96; bus.amount = 3'd3;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.sr_a !== 8'h96 || bus.sr_opcode !== 3'd0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL sra_step0 got a=%h op=%0d busy=%b expected a=96 op=0 busy=1", bus.sr_a, bus.sr_opcode, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.sr_a !== 8'hCB) begin
            errors++;
            $display("FAIL sra_step1 got %h expected cb", bus.sr_a);
        end
        @(negedge clk);
        checks++;
        if (bus.sr_a !== 8'hE5 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL sra_step2 got a=%h done=%b expected a=e5 done=0", bus.sr_a, bus.done);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.result_out !== 8'hF2 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL sra_done got done=%b res=%h err=%b expected done=1 res=f2 err=0", bus.done, bus.result_out, bus.err);
        end
        @(negedge clk);
        $display("test_sra sra 0x96 by 3 done");
    endtask

    task automatic test_rotate();
        int lat; logic [7:0] res; logic e; bit sb;
        run_op(3'd4, 8'h81, 3'd2, lat, res, e, sb);
        checks++;
        if (lat !== 2 || res !== 8'h60) begin
            errors++;
            $display("FAIL ror_81_2 got lat=%0d res=%h expected lat=2 res=60", lat, res);
        end
        @(negedge clk);
        run_op(3'd5, 8'h81, 3'd1, lat, res, e, sb);
        checks++;
        if (lat !== 1 || res !== 8'h03) begin
            errors++;
            $display("FAIL rol_81_1 got lat=%0d res=%h expected lat=1 res=03", lat, res);
        end
        @(negedge clk);
        $display("test_rotate ror/rol done");
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] res; logic e; bit sb;
        run_op(3'd3, 8'hFF, 3'd7, lat, res, e, sb);
        checks++;
        if (lat !== 7 || res !== 8'h80) begin
            errors++;
            $display("FAIL sll_ff_7 got lat=%0d res=%h expected lat=7 res=80", lat, res);
        end
        // Issued during the DONE cycle of the previous operation
        run_op(3'd1, 8'h80, 3'd7, lat, res, e, sb);
        checks++;
        if (lat !== 7 || res !== 8'h01 || sb !== 1'b1) begin
            errors++;
            $display("FAIL b2b_srl got lat=%0d res=%h busy=%b expected lat=7 res=01 busy=1", lat, res, sb);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.result_out !== 8'h01) begin
            errors++;
            $display("FAIL b2b_hold got done=%b res=%h expected done=0 res=01", bus.done, bus.result_out);
        end
        $display("test_back_to_back sll then srl done");
    endtask

    task automatic test_zero_amount();
        int lat; logic [7:0] res; logic e; bit sb;
        logic [2:0] op;
        op = 3'($urandom_range(0, 5));
        run_op(op, 8'h5A, 3'd0, lat, res, e, sb);
        checks++;
        if (lat !== 0 || res !== 8'h5A || sb !== 1'b0 || e !== 1'b0) begin
            errors++;
            $display("FAIL zero_amount op=%0d got lat=%0d res=%h busy=%b err=%b expected lat=0 res=5a busy=0 err=0", op, lat, res, sb, e);
        end
        @(negedge clk);
        $display("test_zero_amount op=%0d done", op);
    endtask

    task automatic test_invalid();
        int lat; logic [7:0] res; logic e; bit sb;
        run_op(3'b110, 8'h3C, 3'($urandom_range(0, 7)), lat, res, e, sb);
        checks++;
        if (lat !== 0 || e !== 1'b1 || res !== 8'h00 || sb !== 1'b0) begin
            errors++;
            $display("FAIL invalid_op got lat=%0d err=%b res=%h busy=%b expected lat=0 err=1 res=00 busy=0", lat, e, res, sb);
        end
        @(negedge clk);
        run_op(3'd2, 8'h3C, 3'd2, lat, res, e, sb);
        checks++;
        if (e !== 1'b0 || res !== ref_result(3'd2, 8'h3C, 2) || lat !== 2) begin
            errors++;
            $display("FAIL invalid_clear got err=%b res=%h lat=%0d expected err=0 res=%h lat=2", e, res, lat, ref_result(3'd2, 8'h3C, 2));
        end
        @(negedge clk);
        $display("test_invalid done");
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        bus.start = 1'b1; bus.op_in = 3'd1; bus.data_in = 8'hF0; bus.amount = 3'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.result_out, bus.sr_a, bus.sr_opcode} !== 22'h0) begin
            errors++;
            $display("FAIL reset_mid_op got busy=%b done=%b err=%b res=%h a=%h op=%0d expected all 0",
                     bus.busy, bus.done, bus.err, bus.result_out, bus.sr_a, bus.sr_opcode);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done got activity=%b expected 0", seen);
        end
        $display("test_reset_mid_op done");
    endtask

    task automatic test_busy_start();
        int lat; logic [7:0] exp_res;
        exp_res = ref_result(3'd5, 8'hA5, 5);
        bus.start = 1'b1; bus.op_in = 3'd5; bus.data_in = 8'hA5; bus.amount = 3'd5;
        @(negedge clk);
        lat = -1;
        for (int c = 0; c <= 20; c++) begin
            if (bus.done) begin
                lat = c;
                break;
            end
            // Competing requests while busy must be ignored
            bus.start   = (c < 3);
            bus.op_in   = 3'($urandom_range(0, 5));
            bus.data_in = 8'($urandom);
            bus.amount  = 3'($urandom_range(1, 7));
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (lat !== 5 || bus.result_out !== exp_res) begin
            errors++;
            $display("FAIL busy_start got lat=%0d res=%h expected lat=5 res=%h", lat, bus.result_out, exp_res);
        end
        @(negedge clk);
        $display("test_busy_start done");
    endtask

    task automatic test_random();
        int lat; logic [7:0] res; logic e; bit sb;
        logic [2:0] op; logic [7:0] d; logic [2:0] n;
        int exp_lat; logic [7:0] exp_res; logic exp_err; bit exp_busy;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            n  = 3'($urandom_range(0, 7));
            exp_err  = (op > 3'd5);
            exp_lat  = exp_err ? 0 : int'(n);
            exp_res  = ref_result(op, d, int'(n));
            exp_busy = !exp_err && (n != 3'd0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            run_op(op, d, n, lat, res, e, sb);
            checks++;
            if (lat !== exp_lat || res !== exp_res || e !== exp_err || sb !== exp_busy) begin
                errors++;
                $display("FAIL random_%0d op=%0d d=%h n=%0d got lat=%0d res=%h err=%b busy=%b expected lat=%0d res=%h err=%b busy=%b",
                         i, op, d, n, lat, res, e, sb, exp_lat, exp_res, exp_err, exp_busy);
            end else begin
                $display("random_%0d op=%0d d=%h n=%0d res=%h err=%b lat=%0d", i, op, d, n, res, e, lat);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.op_in   = 3'd0;
        bus.data_in = 8'h00;
        bus.amount  = 3'd0;
        rst_n       = 1'b0;
        test_reset();
        test_sra();
        test_rotate();
        test_back_to_back();
        test_zero_amount();
        test_invalid();
        test_reset_mid_op();
        test_busy_start();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
